// File: rtl/pwm_deadtime.sv
// Dead-time generator: turns one PWM bit into a complementary hi/lo gate pair with programmable dead time.
// Optional latched fault shutdown when PWM_DEADTIME_FAULT_EN is defined.
module pwm_deadtime #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pwm_in,
  input  logic [W-1:0] dt_d,
  input  logic         dt_we,
`ifdef PWM_DEADTIME_FAULT_EN
  input  logic         fault_in,
  input  logic         fault_clr,
  output logic         fault_o,
`endif
  output logic         out_hi,
  output logic         out_lo,
  output logic         dead,
  output logic         glitch,
  output logic [W-1:0] dt
);

`ifdef PWM_DEADTIME_FAULT_EN
  typedef enum logic [2:0] {LO_ON, DEAD_RISE, HI_ON, DEAD_FALL, FAULT} state_t;
`else
  typedef enum logic [1:0] {LO_ON, DEAD_RISE, HI_ON, DEAD_FALL} state_t;
`endif

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] dt_q;
  logic         pwm_q;
  logic         glitch_d;
  logic         out_hi_q, out_lo_q, dead_q, glitch_q;
`ifdef PWM_DEADTIME_FAULT_EN
  logic         fault_q;
`endif

  // Abort check comes before the count check so a pulse of exactly dt cycles is suppressed.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = 1'b0;
    case (state_q)
      LO_ON:
        if (pwm_q) begin
          if (dt_q == '0) state_d = HI_ON;
          else begin
            state_d = DEAD_RISE;
            cnt_d   = dt_q - ONE;
          end
        end
      DEAD_RISE:
        if (!pwm_q) begin
          state_d  = LO_ON;
          glitch_d = 1'b1;
        end else if (cnt_q == '0) state_d = HI_ON;
        else cnt_d = cnt_q - ONE;
      HI_ON:
        if (!pwm_q) begin
          if (dt_q == '0) state_d = LO_ON;
          else begin
            state_d = DEAD_FALL;
            cnt_d   = dt_q - ONE;
          end
        end
      DEAD_FALL:
        if (pwm_q) begin
          state_d  = HI_ON;
          glitch_d = 1'b1;
        end else if (cnt_q == '0) state_d = LO_ON;
        else cnt_d = cnt_q - ONE;
`ifdef PWM_DEADTIME_FAULT_EN
      FAULT:
        if (fault_clr && !fault_in) begin
          state_d = DEAD_FALL;
          cnt_d   = dt_q;
        end
`endif
      default: state_d = DEAD_FALL;
    endcase
`ifdef PWM_DEADTIME_FAULT_EN
    // Fault overrides every transition and freezes the counter.
    if (fault_in) begin
      state_d  = FAULT;
      cnt_d    = cnt_q;
      glitch_d = 1'b0;
    end
`endif
  end

  // Outputs are decoded from the next state so they are flops aligned with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DEAD_FALL;
      cnt_q    <= '0;
      pwm_q    <= 1'b0;
      dt_q     <= '0;
      out_hi_q <= 1'b0;
      out_lo_q <= 1'b0;
      dead_q   <= 1'b1;
      glitch_q <= 1'b0;
`ifdef PWM_DEADTIME_FAULT_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_in;
      if (dt_we) dt_q <= dt_d;
      out_hi_q <= (state_d == HI_ON);
      out_lo_q <= (state_d == LO_ON);
      dead_q   <= (state_d == DEAD_RISE) || (state_d == DEAD_FALL);
      glitch_q <= glitch_d;
`ifdef PWM_DEADTIME_FAULT_EN
      fault_q  <= (state_d == FAULT);
`endif
    end
  end

  assign out_hi = out_hi_q;
  assign out_lo = out_lo_q;
  assign dead   = dead_q;
  assign glitch = glitch_q;
  assign dt     = dt_q;
`ifdef PWM_DEADTIME_FAULT_EN
  assign fault_o = fault_q;
`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: waveform masks per pulse pattern, dt readback, async reset, optional fault.
module tb_pwm_deadtime;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pwm_in;
  logic [W-1:0] dt_d;
  logic         dt_we;
  logic         out_hi, out_lo, dead, glitch;
  logic [W-1:0] dt;
`ifdef PWM_DEADTIME_FAULT_EN
  logic         fault_in, fault_clr, fault_o;
`endif

  int total = 0;
  int bad   = 0;
  int overlap = 0;
  logic [31:0] hi_m, lo_m, dead_m, gl_m;

  pwm_deadtime #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .dt_d(dt_d), .dt_we(dt_we),
`ifdef PWM_DEADTIME_FAULT_EN
    .fault_in(fault_in), .fault_clr(fault_clr), .fault_o(fault_o),
`endif
    .out_hi(out_hi), .out_lo(out_lo), .dead(dead), .glitch(glitch), .dt(dt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_hi && out_lo) overlap++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_dt(input logic [W-1:0] v);
    dt_we = 1'b1; dt_d = v;
    @(negedge clk);
    dt_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // pat[k] is pwm_in for edge N+k; sample i is taken after edge N+i. Optional dt write at sample wr_at.
  task automatic run_seq(input logic [31:0] pat, input int len, input int wr_at, input logic [W-1:0] wr_val);
    hi_m = '0; lo_m = '0; dead_m = '0; gl_m = '0;
    pwm_in = pat[0];
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      hi_m[i] = out_hi; lo_m[i] = out_lo; dead_m[i] = dead; gl_m[i] = glitch;
      pwm_in = (i + 1 < 32) ? pat[i+1] : 1'b0;
      if (i == wr_at) begin dt_we = 1'b1; dt_d = wr_val; end
      else dt_we = 1'b0;
    end
    pwm_in = 1'b0;
    dt_we  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pwm_in = 1'b0; dt_d = '0; dt_we = 1'b0;
`ifdef PWM_DEADTIME_FAULT_EN
    fault_in = 1'b0; fault_clr = 1'b0;
`endif
    @(negedge clk); @(negedge clk);
    chk("rst_hi", out_hi, 0);
    chk("rst_lo", out_lo, 0);
    chk("rst_dead", dead, 1);
    chk("rst_glitch", glitch, 0);
    chk("rst_dt", dt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_lo", out_lo, 1);
    chk("idle_hi", out_hi, 0);
    chk("idle_dead", dead, 0);
    @(negedge clk);
    chk("idle_lo2", out_lo, 1);

    // dt=3, 10-cycle pulse
    load_dt(3);
    chk("dt3", dt, 3);
    run_seq(32'h3FF, 16, -1, '0);
    chk("p10_hi", hi_m, 32'h0000_07F0);
    chk("p10_lo", lo_m, 32'h0000_C001);
    chk("p10_dead", dead_m, 32'h0000_380E);
    chk("p10_gl", gl_m, 0);

    // dt=3, short low gap aborts the falling dead interval
    run_seq(32'h000F_FCFF, 24, -1, '0);
    chk("gap_hi", hi_m, 32'h001F_F9F0);
    chk("gap_lo", lo_m, 32'h0000_0001);
    chk("gap_dead", dead_m, 32'h00E0_060E);
    chk("gap_gl", gl_m, 32'h0000_0800);

    // dt=5, 4-cycle pulse suppressed
    load_dt(5);
    chk("dt5", dt, 5);
    run_seq(32'hF, 10, -1, '0);
    chk("short_hi", hi_m, 0);
    chk("short_lo", lo_m, 32'h0000_03E1);
    chk("short_dead", dead_m, 32'h0000_001E);
    chk("short_gl", gl_m, 32'h0000_0020);

    // dt=0, period-2 square wave: direct swap every cycle
    load_dt(0);
    run_seq(32'h555, 12, -1, '0);
    chk("sq_hi", hi_m, 32'h0000_0AAA);
    chk("sq_lo", lo_m, 32'h0000_0555);
    chk("sq_dead", dead_m, 0);
    chk("sq_gl", gl_m, 0);

    // dt=6, rewrite to 2 mid-interval
    load_dt(6);
    run_seq(32'hFFF, 24, 2, 2);
    chk("wr_dt", dt, 2);
    chk("wr_hi", hi_m, 32'h0000_1F80);
    chk("wr_lo", lo_m, 32'h00FF_8001);
    chk("wr_dead", dead_m, 32'h0000_607E);
    chk("wr_gl", gl_m, 0);

    // async reset mid HI_ON
    pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_rst_hi", out_hi, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", out_hi, 0);
    chk("arst_lo", out_lo, 0);
    chk("arst_dead", dead, 1);
    chk("arst_dt", dt, 0);
    chk("arst_gl", glitch, 0);
    pwm_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_lo", out_lo, 1);

`ifdef PWM_DEADTIME_FAULT_EN
    load_dt(2);
    pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("f_pre_hi", out_hi, 1);
    fault_in = 1'b1;
    @(negedge clk);
    chk("f_hi", out_hi, 0);
    chk("f_lo", out_lo, 0);
    chk("f_dead", dead, 0);
    chk("f_fault", fault_o, 1);
    fault_clr = 1'b1; pwm_in = 1'b0;
    @(negedge clk);
    chk("f_clr_ign", fault_o, 1);
    fault_in = 1'b0;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("f_clr_dead", dead, 1);
    chk("f_clr_fault", fault_o, 0);
    begin
      int n = 0;
      while (!out_lo && n < 8) begin @(negedge clk); n++; end
      chk("f_lo_back", out_lo, 1);
    end
`endif

    chk("never_both", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
